// File: rtl/logic_func_pipe_pkg.sv
// Shared opcode encoding and the bitwise operator used by both pipeline stages.
package logic_func_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_OR   = 2'b00;
  localparam op_t OP_AND  = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_NAND = 2'b11;

  // Widest lane apply_op handles; callers zero-extend operands and truncate the result.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] apply_op(input op_t op,
                                               input logic [MAX_W-1:0] x,
                                               input logic [MAX_W-1:0] y);
    logic [MAX_W-1:0] r;
    case (op)
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_XOR:  r = x ^ y;
      default: r = ~(x & y);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_func_pipe_if.sv
// Input/output handshake bundle of logic_func_pipe; slave is the pipeline side.
interface logic_func_pipe_if
  import logic_func_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  op_t              op1;
  op_t              op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f1;
  logic [WIDTH-1:0] f2;

  modport master (
    output in_valid, a, b, c, op1, op2, out_ready,
    input  in_ready, out_valid, f1, f2
  );

  modport slave (
    input  in_valid, a, b, c, op1, op2, out_ready,
    output in_ready, out_valid, f1, f2
  );
endinterface

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice: loads when empty or draining, holds while stalled.
module logic_pipe_stage #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Payload is kept when not loading so a consumer ignoring out_valid sees the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/logic_func_pipe.sv
// Two-stage registered boolean pipeline: f1 = OP1(a,b), f2 = OP2(f1,c), with a handoff counter.
module logic_func_pipe
  import logic_func_pkg::*;
#(
  parameter int WIDTH  = 8,   // must not exceed MAX_W
  parameter int F1_RST = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_func_pipe_if.slave bus,
  output logic [CNT_W-1:0] result_count
);

  localparam int              P1_W   = 2*WIDTH + 2;
  localparam int              P2_W   = 2*WIDTH;
  localparam logic [P2_W-1:0] P2_RST = {{WIDTH{F1_RST[0]}}, {WIDTH{1'b0}}};

  // ---- stage 0: OP1 in front of the first slice; op2 and c ride along ----
  logic [WIDTH-1:0] f1_p0;
  logic [P1_W-1:0]  pay_p0;
  logic [P1_W-1:0]  pay_p1;
  logic             vld_p1;
  logic             rdy_p1;

  assign f1_p0  = WIDTH'(apply_op(bus.op1, MAX_W'(bus.a), MAX_W'(bus.b)));
  assign pay_p0 = {f1_p0, bus.c, bus.op2};

  logic_pipe_stage #(
    .W       (P1_W),
    .RST_VAL ('0)
  ) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_p0),
    .out_valid (vld_p1),
    .out_ready (rdy_p1),
    .out_data  (pay_p1)
  );

  // ---- stage 1: OP2 on the registered f1 so f1/f2 always come from one input ----
  logic [WIDTH-1:0] f1_p1;
  logic [WIDTH-1:0] c_p1;
  logic [WIDTH-1:0] f2_p1;
  op_t              op2_p1;
  logic [P2_W-1:0]  pay_p2;

  assign {f1_p1, c_p1, op2_p1} = pay_p1;
  assign f2_p1 = WIDTH'(apply_op(op2_p1, MAX_W'(f1_p1), MAX_W'(c_p1)));

  logic_pipe_stage #(
    .W       (P2_W),
    .RST_VAL (P2_RST)
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p1),
    .in_data   ({f1_p1, f2_p1}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_p2)
  );

  // ---- stage 2: output register drives the bus ----
  assign bus.f1 = pay_p2[P2_W-1 -: WIDTH];
  assign bus.f2 = pay_p2[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      result_count <= result_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_func_pipe.sv
// Scoreboard bench: a WIDTH=8/CNT_W=3 pipe under random traffic plus a WIDTH=1 pipe for latency.
`timescale 1ns/1ps
module tb_logic_func_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_func_pipe_if #(.WIDTH(8)) bus8();
  logic_func_pipe_if #(.WIDTH(1)) bus1();
  logic [2:0]  cnt8;
  logic [15:0] cnt1;

  logic_func_pipe #(.WIDTH(8), .F1_RST(1), .CNT_W(3)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .result_count(cnt8));
  logic_func_pipe #(.WIDTH(1), .F1_RST(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .result_count(cnt1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  logic [15:0] exp_q[$];
  int          acc_cyc[$];
  int          ho_cyc[$];
  logic [2:0]  exp_cnt = 3'd0;
  logic        stall_prev = 1'b0;
  logic [7:0]  pf1, pf2, f1e;
  logic [15:0] e;
  logic        rnd_done;

  // Reference semantics of the four opcodes.
  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      2'd0:    return x | y;
      2'd1:    return x & y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard: accepts push the model result, handoffs pop and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt    = 3'd0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(bus8.out_valid), 32'd1);
        check("hold_f1", 32'(bus8.f1), 32'(pf1));
        check("hold_f2", 32'(bus8.f2), 32'(pf2));
      end
      check("count", 32'(cnt8), 32'(exp_cnt));
      if (bus8.out_valid && bus8.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got f1=%h f2=%h want no output", bus8.f1, bus8.f2);
        end else begin
          e = exp_q.pop_front();
          check("f1", 32'(bus8.f1), 32'(e[15:8]));
          check("f2", 32'(bus8.f2), 32'(e[7:0]));
        end
        exp_cnt = exp_cnt + 3'd1;
        ho_cyc.push_back(cyc);
      end
      if (bus8.in_valid && bus8.in_ready) begin
        f1e = ref_op(bus8.op1, bus8.a, bus8.b);
        exp_q.push_back({f1e, ref_op(bus8.op2, f1e, bus8.c)});
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      stall_prev = bus8.out_valid && !bus8.out_ready;
      pf1 = bus8.f1;
      pf2 = bus8.f2;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [1:0] o1, input logic [1:0] o2);
    int k;
    k = 0;
    bus8.a = a; bus8.b = b; bus8.c = c; bus8.op1 = o1; bus8.op2 = o2;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    while (!bus8.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("send_accept", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    bus8.op1 = 2'(~o1);  // opcode changes outside accept must be ignored
    bus8.op2 = 2'(~o2);
  endtask

  task automatic send_rand();
    send8(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] c0;
    int a0, a_base, h_base, k;
    logic done4;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c = '0;
    bus8.op1 = '0; bus8.op2 = '0; bus8.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c = '0;
    bus1.op1 = '0; bus1.op2 = '0; bus1.out_ready = 1'b1;
    rnd_done = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("u1_rst_f1", 32'(bus1.f1), 32'd1);
    check("u1_rst_cnt", 32'(cnt1), 32'd0);

    // Reset with two transactions in flight.
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
    send_rand();
    send_rand();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_f1", 32'(bus8.f1), 32'hFF);
    check("rst_f2", 32'(bus8.f2), 32'h00);
    check("rst_count", 32'(cnt8), 32'd0);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 bus8.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("rst_no_partial", 32'(bus8.out_valid), 32'd0);

    // Nine handoffs wrap the 3-bit counter to 1.
    for (int i = 0; i < 9; i++) send_rand();
    repeat (3) @(posedge clk);
    #1 check("wrap_count", 32'(cnt8), 32'd1);

    // Single WIDTH=1 transaction: OR then AND, result two edges after accept.
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b1; bus1.op1 = 2'd0; bus1.op2 = 2'd1;
    bus1.in_valid = 1'b1;
    @(negedge clk) check("w1_in_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    @(negedge clk) check("w1_lat_n1", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    check("w1_out_valid", 32'(bus1.out_valid), 32'd1);
    check("w1_f1", 32'(bus1.f1), 32'd1);
    check("w1_f2", 32'(bus1.f2), 32'd1);
    @(negedge clk);
    check("w1_drained", 32'(bus1.out_valid), 32'd0);
    check("w1_count", 32'(cnt1), 32'd1);
    @(posedge clk);
    #1;

    // XOR then NAND on fixed operands.
    send8(8'hF0, 8'h3C, 8'h0F, 2'd2, 2'd3);
    k = 0;
    @(negedge clk);
    while (!bus8.out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("ops_valid", 32'(bus8.out_valid), 32'd1);
    check("ops_f1", 32'(bus8.f1), 32'hCC);
    check("ops_f2", 32'(bus8.f2), 32'hF3);
    @(posedge clk);
    #1;

    // Backpressure: four streamed, downstream stalled three cycles.
    repeat (2) @(posedge clk);
    #1 bus8.out_ready = 1'b0;
    c0 = cnt8;
    a0 = n_acc;
    done4 = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
        done4 = 1'b1;
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("bp_accepts", 32'(n_acc - a0), 32'd2);
    check("bp_in_ready", 32'(bus8.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus8.out_valid), 32'd1);
    bus8.out_ready = 1'b1;
    k = 0;
    while (!done4 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1 check("bp_sender_done", 32'(done4), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_all_accepted", 32'(n_acc - a0), 32'd4);
    check("bp_count", 32'(cnt8), 32'(3'(c0 + 3'd4)));

    // Throughput: ten back-to-back with distinct a.
    a_base = acc_cyc.size();
    h_base = ho_cyc.size();
    for (int i = 0; i < 10; i++)
      send8(8'(i * 16 + 3), 8'($urandom), 8'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)));
    repeat (3) @(posedge clk);
    #1;
    check("tp_handoffs", 32'(ho_cyc.size() - h_base), 32'd10);
    if (ho_cyc.size() - h_base == 10 && acc_cyc.size() - a_base == 10) begin
      for (int i = 0; i < 10; i++) begin
        check("tp_acc_cycle", 32'(acc_cyc[a_base + i]), 32'(acc_cyc[a_base] + i));
        check("tp_out_cycle", 32'(ho_cyc[h_base + i]), 32'(acc_cyc[a_base] + 2 + i));
      end
    end

    // Random traffic with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send_rand();
          repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        for (int j = 0; j < 5000 && !rnd_done; j++) begin
          @(posedge clk);
          #1 bus8.out_ready = 1'($urandom_range(1));
        end
      end
    join
    bus8.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
